vec_element_sequencer: RTL and testbench
========================================

// Module: vec_element_sequencer
// PURPOSE
//  Initiator side of the vector processing-element interface. Accepts one decoded vector op.
//  Walks elements 0..vl-1 and reads each operand pair from the vector register file (VRF).
//  Drives the combinational lane PE (a, b, funct6) and writes each pe_result back to vd.
//  Sits between vector decode/issue and the VRF.
// PARAMETERS
//  ELEN   32  element width in bits; must match the PE data width
//  VLMAX  8   max elements per vector register (power of 2)
//  IDX_W  3   element index width, $clog2(VLMAX)
// PORTS
//  clk              in   1        clock; all state changes on the rising edge
//  rst_n            in   1        asynchronous, active-low reset
//  flush            in   1        synchronous abort of the in-flight op
//  issue_valid      in   1        decode presents an op
//  issue_ready      out  1        sequencer can accept (state IDLE)
//  issue_funct6     in   6        PE opcode (VADD/VSUB/VAND/VOR/VXOR/VMV/VSLIDEUP/VSLIDEDOWN)
//  issue_vd         in   5        destination vector register
//  issue_vs1        in   5        source register 1
//  issue_vs2        in   5        source register 2
//  issue_use_scalar in   1        1: operand b = issue_rs1_val (.vx form)
//  issue_rs1_val    in   ELEN     scalar operand
//  issue_vl         in   IDX_W+1  element count, 0..VLMAX
//  vrf_rd_en        out  1        VRF read strobe; data returns next cycle
//  vrf_rd_reg_a     out  5        read register for operand a
//  vrf_rd_reg_b     out  5        read register for operand b
//  vrf_rd_idx       out  IDX_W    element index for both reads
//  vrf_rd_data_a    in   ELEN     element data, 1 cycle after vrf_rd_en
//  vrf_rd_data_b    in   ELEN     element data, 1 cycle after vrf_rd_en
//  pe_a, pe_b       out  ELEN     PE operands
//  pe_funct6        out  6        PE opcode
//  pe_result        in   ELEN     PE combinational result
//  vrf_wr_en        out  1        VRF write strobe
//  vrf_wr_reg       out  5        write register (latched vd)
//  vrf_wr_idx       out  IDX_W    write element index
//  vrf_wr_data      out  ELEN     = pe_result
//  busy             out  1        state != IDLE
//  done             out  1        1-cycle pulse on the final write, or on the vl=0 completion
// BEHAVIOUR
//  - Reset: state IDLE, all strobes 0, all index/data/reg outputs 0; issue_ready=1.
//  - Accept: issue_valid && issue_ready latches funct6, vd, vs1, vs2, use_scalar, rs1_val and
//    vl_eff = min(issue_vl, VLMAX). Inputs are ignored when not accepted.
//  - Operand routing: VMV gives a=vs1, b unused (0). All other ops give a=vs2, b=vs1 or scalar.
//    pe_funct6 = latched funct6.
//  - FSM states:
//    - IDLE -> RUN on accept with vl_eff>0.
//    - IDLE -> DONE on accept with vl_eff=0: no reads or writes; done=1 on the next cycle.
//    - RUN: read counter rc runs 0..vl_eff-1, one element per cycle. vrf_rd_en=1 and vrf_rd_idx=rc.
//      After issuing rc=vl_eff-1, go to DRAIN.
//    - DRAIN: one cycle for the last write, then IDLE.
//    - DONE: one cycle with done=1, then IDLE.
//  - Write pipeline: a 1-cycle valid/idx register follows the read. When set: vrf_wr_en=1,
//    vrf_wr_idx=the read idx, vrf_wr_data=pe_result. pe_a/pe_b come straight from vrf_rd_data_*,
//    with the scalar replacing pe_b when use_scalar=1.
//  - Timing: accept on cycle 0; element i is read on cycle 1+i and written on cycle 2+i.
//    done=1 on cycle vl_eff+1 (the last write). issue_ready returns on cycle vl_eff+2.
//  - No write backpressure: the VRF write port always accepts.
//  - vd equal to vs1 or vs2 is legal. Each element is read before it is written, so results stay correct.
//  - flush (wins over everything): state goes to IDLE next cycle. The pending write is dropped,
//    no done pulse is produced, and no further strobes occur.
//  - flush together with issue_valid in IDLE: the op is not accepted.
//  - Async reset mid-op: same as flush, immediately.
// TESTING
//  - VADD vl=4: vs2={1,2,3,4}, vs1={10,20,30,40} -> vd={11,22,33,44} on cycles 2..5; done on cycle 5.
//  - VSUB .vx vl=8 with rs1_val=1: vs2=0..7 -> vd={FFFFFFFF,0,1,...,6}; vrf_rd_reg_b is ignored.
//  - VMV vl=3: vs1={A,B,C} -> vd={A,B,C}; vs2 data is ignored; one write per element, idx 0..2.
//  - vl=0 -> zero VRF strobes, done on cycle 1, ready on cycle 2.
//  - vl=12 (>VLMAX) -> exactly 8 writes.
//  - flush asserted on cycle 3 of a vl=8 op -> no writes after cycle 3, no done.
//  - rst_n pulled low mid-op -> all outputs 0 immediately.
//  - Back-to-back: hold issue_valid=1 -> the second op is accepted on the cycle ready rises.
//    Also run an op with vd=vs2 and check each element's result is correct.

Source files
------------

// File: rtl/vec_element_sequencer.sv
// Vector element sequencer: walks elements 0..vl-1 of one decoded op, reads operand pairs
// from the VRF, drives the combinational lane PE and writes each result back to vd.
module vec_element_sequencer #(
   parameter int ELEN  = 32,
   parameter int VLMAX = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [5:0]       issue_funct6,
   input  logic [4:0]       issue_vd,
   input  logic [4:0]       issue_vs1,
   input  logic [4:0]       issue_vs2,
   input  logic             issue_use_scalar,
   input  logic [ELEN-1:0]  issue_rs1_val,
   input  logic [IDX_W:0]   issue_vl,
   output logic             vrf_rd_en,
   output logic [4:0]       vrf_rd_reg_a,
   output logic [4:0]       vrf_rd_reg_b,
   output logic [IDX_W-1:0] vrf_rd_idx,
   input  logic [ELEN-1:0]  vrf_rd_data_a,
   input  logic [ELEN-1:0]  vrf_rd_data_b,
   output logic [ELEN-1:0]  pe_a,
   output logic [ELEN-1:0]  pe_b,
   output logic [5:0]       pe_funct6,
   input  logic [ELEN-1:0]  pe_result,
   output logic             vrf_wr_en,
   output logic [4:0]       vrf_wr_reg,
   output logic [IDX_W-1:0] vrf_wr_idx,
   output logic [ELEN-1:0]  vrf_wr_data,
   output logic             busy,
   output logic             done
);
   localparam logic [5:0]     VMV     = 6'b010111;
   localparam logic [IDX_W:0] VLMAX_V = (IDX_W+1)'(VLMAX);
   localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  rc_reg;
   logic [IDX_W:0]    vl_reg;
   logic [5:0]        funct6_reg;
   logic [4:0]        vd_reg, vs1_reg, vs2_reg;
   logic              use_scalar_reg;
   logic [ELEN-1:0]   rs1_val_reg;
   logic              wr_valid_reg;
   logic [IDX_W-1:0]  wr_idx_reg;

   logic              accept;
   logic              last_rd;
   logic              is_vmv;
   logic [IDX_W:0]    vl_clamped;

   assign accept     = issue_valid && (state_reg == IDLE) && !flush;
   assign vl_clamped = (issue_vl > VLMAX_V) ? VLMAX_V : issue_vl;
   assign last_rd    = ({1'b0, rc_reg} == (vl_reg - ONE));
   assign is_vmv     = (funct6_reg == VMV);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = (vl_clamped == '0) ? DONE : RUN;
         RUN:     if (last_rd) state_next = DRAIN;
         DRAIN:   state_next = IDLE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // flush aborts from any state; the pending write is squashed below
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         rc_reg         <= '0;
         vl_reg         <= '0;
         funct6_reg     <= '0;
         vd_reg         <= '0;
         vs1_reg        <= '0;
         vs2_reg        <= '0;
         use_scalar_reg <= 1'b0;
         rs1_val_reg    <= '0;
         wr_valid_reg   <= 1'b0;
         wr_idx_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         wr_valid_reg <= (state_reg == RUN) && !flush;
         wr_idx_reg   <= rc_reg;
         if (accept) begin
            rc_reg         <= '0;
            vl_reg         <= vl_clamped;
            funct6_reg     <= issue_funct6;
            vd_reg         <= issue_vd;
            vs1_reg        <= issue_vs1;
            vs2_reg        <= issue_vs2;
            use_scalar_reg <= issue_use_scalar;
            rs1_val_reg    <= issue_rs1_val;
         end else if (state_reg == RUN && !last_rd) begin
            rc_reg <= rc_reg + IDX_W'(1);
         end
      end
   end

   assign issue_ready  = (state_reg == IDLE);
   assign busy         = (state_reg != IDLE);
   assign done         = ((state_reg == DRAIN) || (state_reg == DONE)) && !flush;

   assign vrf_rd_en    = (state_reg == RUN) && !flush;
   assign vrf_rd_idx   = rc_reg;
   assign vrf_rd_reg_a = is_vmv ? vs1_reg : vs2_reg;
   assign vrf_rd_reg_b = is_vmv ? 5'd0 : vs1_reg;

   // Operands are only meaningful in the cycle after a read; hold them at 0 otherwise
   assign pe_a      = wr_valid_reg ? vrf_rd_data_a : '0;
   assign pe_b      = (!wr_valid_reg || is_vmv) ? '0 :
                      (use_scalar_reg ? rs1_val_reg : vrf_rd_data_b);
   assign pe_funct6 = funct6_reg;

   assign vrf_wr_en   = wr_valid_reg && !flush;
   assign vrf_wr_reg  = vd_reg;
   assign vrf_wr_idx  = wr_idx_reg;
   assign vrf_wr_data = wr_valid_reg ? pe_result : '0;
endmodule

// File: tb/tb_vec_element_sequencer.sv
// Directed bench for vec_element_sequencer with a behavioural VRF and lane PE around the DUT.
module tb_vec_element_sequencer;
   localparam logic [5:0] VADD = 6'b000000, VSUB = 6'b000010, VAND = 6'b001001,
                          VOR  = 6'b001010, VXOR = 6'b001011, VMV  = 6'b010111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [5:0]  issue_funct6 = '0;
   logic [4:0]  issue_vd = '0, issue_vs1 = '0, issue_vs2 = '0;
   logic        issue_use_scalar = 1'b0;
   logic [31:0] issue_rs1_val = '0;
   logic [3:0]  issue_vl = '0;
   logic        vrf_rd_en;
   logic [4:0]  vrf_rd_reg_a, vrf_rd_reg_b;
   logic [2:0]  vrf_rd_idx;
   logic [31:0] vrf_rd_data_a, vrf_rd_data_b;
   logic [31:0] pe_a, pe_b, pe_result;
   logic [5:0]  pe_funct6;
   logic        vrf_wr_en;
   logic [4:0]  vrf_wr_reg;
   logic [2:0]  vrf_wr_idx;
   logic [31:0] vrf_wr_data;
   logic        busy, done;

   vec_element_sequencer #(.ELEN(32), .VLMAX(8), .IDX_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_funct6(issue_funct6), .issue_vd(issue_vd), .issue_vs1(issue_vs1),
      .issue_vs2(issue_vs2), .issue_use_scalar(issue_use_scalar),
      .issue_rs1_val(issue_rs1_val), .issue_vl(issue_vl),
      .vrf_rd_en(vrf_rd_en), .vrf_rd_reg_a(vrf_rd_reg_a), .vrf_rd_reg_b(vrf_rd_reg_b),
      .vrf_rd_idx(vrf_rd_idx), .vrf_rd_data_a(vrf_rd_data_a), .vrf_rd_data_b(vrf_rd_data_b),
      .pe_a(pe_a), .pe_b(pe_b), .pe_funct6(pe_funct6), .pe_result(pe_result),
      .vrf_wr_en(vrf_wr_en), .vrf_wr_reg(vrf_wr_reg), .vrf_wr_idx(vrf_wr_idx),
      .vrf_wr_data(vrf_wr_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Lane PE model
   always_comb begin
      pe_result = pe_a;
      case (pe_funct6)
         VADD:    pe_result = pe_a + pe_b;
         VSUB:    pe_result = pe_a - pe_b;
         VAND:    pe_result = pe_a & pe_b;
         VOR:     pe_result = pe_a | pe_b;
         VXOR:    pe_result = pe_a ^ pe_b;
         VMV:     pe_result = pe_a;
         default: pe_result = pe_a;
      endcase
   end

   // VRF model with a bench load port
   logic [31:0] vrf [32][8];
   logic        ld_en = 1'b0;
   logic [4:0]  ld_reg = '0;
   logic [2:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;
   always @(posedge clk) begin
      if (ld_en) vrf[ld_reg][ld_idx] <= ld_data;
      if (vrf_wr_en) vrf[vrf_wr_reg][vrf_wr_idx] <= vrf_wr_data;
      if (vrf_rd_en) begin
         vrf_rd_data_a <= vrf[vrf_rd_reg_a][vrf_rd_idx];
         vrf_rd_data_b <= vrf[vrf_rd_reg_b][vrf_rd_idx];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled mid-cycle; element i must be written on cycle 2+i of its op
   int start_cyc = 0;
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, idx_err = 0;
   int last_wr_rel = -1, done_rel = -1;
   always @(negedge clk) begin
      if (rst_n) begin
         if (vrf_rd_en) rd_cnt++;
         if (vrf_wr_en) begin
            wr_cnt++;
            last_wr_rel = cyc - start_cyc;
            if (vrf_wr_idx != 3'(cyc - start_cyc - 2)) idx_err++;
         end
         if (done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
         end
      end
   end

   int passed = 0, fails = 0, total = 0;
   int rd0, wr0, dn0, ready_rel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] r, input logic [2:0] i, input logic [31:0] d);
      ld_en = 1'b1; ld_reg = r; ld_idx = i; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   task automatic set_op(input logic [5:0] f, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic us, input logic [31:0] rs1,
                         input logic [3:0] vl);
      issue_funct6 = f; issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2;
      issue_use_scalar = us; issue_rs1_val = rs1; issue_vl = vl;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!issue_ready && n < 40) begin
         step();
         n++;
      end
      ready_rel = cyc - start_cyc;
      chk({tag, "_no_timeout"}, 32'(issue_ready), 32'd1);
   endtask

   // Issue one op (accepted on cycle 0) and wait until ready returns
   task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] vd,
                         input logic [4:0] vs1, input logic [4:0] vs2, input logic us,
                         input logic [31:0] rs1, input logic [3:0] vl);
      set_op(f, vd, vs1, vs2, us, rs1, vl);
      rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
      issue_valid = 1'b1;
      start_cyc = cyc;
      step();
      issue_valid = 1'b0;
      wait_ready(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", {29'd0, vrf_rd_en, vrf_wr_en, done}, 32'd0);
      chk("rst_wr_reg_idx", {24'd0, vrf_wr_reg, vrf_wr_idx}, 32'd0);
      step(); step();
      @(negedge clk) rst_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         load(5'd1, 3'(i), 32'(10 * (i + 1)));
         load(5'd2, 3'(i), 32'(i + 1));
      end
      for (int i = 0; i < 8; i++) load(5'd4, 3'(i), 32'(i));
      load(5'd6, 3'd0, 32'hA); load(5'd6, 3'd1, 32'hB); load(5'd6, 3'd2, 32'hC);
      load(5'd7, 3'd3, 32'h5555);
      load(5'd10, 3'd1, 32'h77);

      // VADD vl=4
      run_op("vadd", VADD, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 4'd4);
      chk("vadd_e0", vrf[3][0], 32'd11);
      chk("vadd_e1", vrf[3][1], 32'd22);
      chk("vadd_e2", vrf[3][2], 32'd33);
      chk("vadd_e3", vrf[3][3], 32'd44);
      chk("vadd_writes", 32'(wr_cnt - wr0), 32'd4);
      chk("vadd_reads", 32'(rd_cnt - rd0), 32'd4);
      chk("vadd_done_cycle", 32'(done_rel), 32'd5);
      chk("vadd_last_wr_cycle", 32'(last_wr_rel), 32'd5);
      chk("vadd_ready_cycle", 32'(ready_rel), 32'd6);
      $display("op vadd vl=4: writes=%0d done_cycle=%0d ready_cycle=%0d", wr_cnt - wr0, done_rel, ready_rel);

      // VSUB .vx vl=8, b from scalar 1
      run_op("vsub_vx", VSUB, 5'd5, 5'd31, 5'd4, 1'b1, 32'd1, 4'd8);
      chk("vsub_e0", vrf[5][0], 32'hFFFF_FFFF);
      chk("vsub_e1", vrf[5][1], 32'd0);
      chk("vsub_e7", vrf[5][7], 32'd6);
      chk("vsub_writes", 32'(wr_cnt - wr0), 32'd8);
      chk("vsub_done_cycle", 32'(done_rel), 32'd9);
      $display("op vsub.vx vl=8: writes=%0d done_cycle=%0d", wr_cnt - wr0, done_rel);

      // VMV vl=3, vs2 contents must not leak in
      run_op("vmv", VMV, 5'd7, 5'd6, 5'd4, 1'b0, 32'd0, 4'd3);
      chk("vmv_e0", vrf[7][0], 32'hA);
      chk("vmv_e1", vrf[7][1], 32'hB);
      chk("vmv_e2", vrf[7][2], 32'hC);
      chk("vmv_e3_untouched", vrf[7][3], 32'h5555);
      chk("vmv_writes", 32'(wr_cnt - wr0), 32'd3);
      $display("op vmv vl=3: writes=%0d", wr_cnt - wr0);

      // vl=0 completes with no VRF traffic
      run_op("vl0", VADD, 5'd12, 5'd1, 5'd2, 1'b0, 32'd0, 4'd0);
      chk("vl0_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
      chk("vl0_done_count", 32'(done_cnt - dn0), 32'd1);
      chk("vl0_done_cycle", 32'(done_rel), 32'd1);
      chk("vl0_ready_cycle", 32'(ready_rel), 32'd2);
      $display("op vl=0: strobes=%0d done_cycle=%0d", (rd_cnt - rd0) + (wr_cnt - wr0), done_rel);

      // vl=12 clamps to 8
      run_op("vl12", VADD, 5'd13, 5'd4, 5'd4, 1'b0, 32'd0, 4'd12);
      chk("vl12_writes", 32'(wr_cnt - wr0), 32'd8);
      chk("vl12_e7", vrf[13][7], 32'd14);
      chk("vl12_ready_cycle", 32'(ready_rel), 32'd10);
      $display("op vl=12: writes=%0d", wr_cnt - wr0);

      // flush on cycle 3 of a vl=8 op: only the cycle-2 write survives
      set_op(VADD, 5'd10, 5'd4, 5'd4, 1'b0, 32'd0, 4'd8);
      wr0 = wr_cnt; dn0 = done_cnt;
      issue_valid = 1'b1;
      start_cyc = cyc;
      step();
      issue_valid = 1'b0;
      step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      step(); step(); step();
      chk("flush_writes", 32'(wr_cnt - wr0), 32'd1);
      chk("flush_no_done", 32'(done_cnt - dn0), 32'd0);
      chk("flush_e1_untouched", vrf[10][1], 32'h77);
      $display("op flush: writes=%0d dones=%0d", wr_cnt - wr0, done_cnt - dn0);

      // flush with issue_valid in IDLE is not accepted
      set_op(VADD, 5'd14, 5'd1, 5'd2, 1'b0, 32'd0, 4'd2);
      issue_valid = 1'b1;
      flush = 1'b1;
      step();
      issue_valid = 1'b0;
      flush = 1'b0;
      chk("flush_idle_busy", 32'(busy), 32'd0);
      $display("op flush+issue idle: busy=%0d", busy);

      // back-to-back with issue_valid held
      set_op(VADD, 5'd8, 5'd1, 5'd2, 1'b0, 32'd0, 4'd2);
      issue_valid = 1'b1;
      start_cyc = cyc;
      step();
      wait_ready("b2b_first");
      chk("b2b_first_ready_cycle", 32'(ready_rel), 32'd4);
      set_op(VXOR, 5'd9, 5'd1, 5'd2, 1'b0, 32'd0, 4'd4);
      start_cyc = cyc;
      step();
      issue_valid = 1'b0;
      chk("b2b_second_accepted", 32'(busy), 32'd1);
      wait_ready("b2b_second");
      chk("b2b_second_ready_cycle", 32'(ready_rel), 32'd6);
      chk("b2b_op1_e1", vrf[8][1], 32'd22);
      chk("b2b_op2_e2", vrf[9][2], 32'd29);
      chk("b2b_op2_e3", vrf[9][3], 32'd44);
      $display("op back-to-back: op1_e1=%0d op2_e2=%0d", vrf[8][1], vrf[9][2]);

      // vd == vs2 overwrites in place
      run_op("inplace", VADD, 5'd2, 5'd1, 5'd2, 1'b0, 32'd0, 4'd4);
      chk("inplace_e0", vrf[2][0], 32'd11);
      chk("inplace_e1", vrf[2][1], 32'd22);
      chk("inplace_e2", vrf[2][2], 32'd33);
      chk("inplace_e3", vrf[2][3], 32'd44);
      $display("op vd=vs2: e3=%0d", vrf[2][3]);

      chk("idx_sequence_errors", 32'(idx_err), 32'd0);

      // async reset mid-op
      run_op("pre_reset", VADD, 5'd11, 5'd4, 5'd4, 1'b0, 32'd0, 4'd0);
      set_op(VSUB, 5'd11, 5'd4, 5'd4, 1'b0, 32'd0, 4'd8);
      issue_valid = 1'b1;
      start_cyc = cyc;
      step();
      issue_valid = 1'b0;
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_strobes", {29'd0, vrf_rd_en, vrf_wr_en, done}, 32'd0);
      chk("arst_busy_ready", {30'd0, busy, issue_ready}, 32'd1);
      chk("arst_regs", {15'd0, vrf_wr_reg, vrf_wr_idx, pe_funct6, vrf_rd_idx}, 32'd0);
      chk("arst_data", pe_a | pe_b | vrf_wr_data, 32'd0);
      $display("op async reset: busy=%0d ready=%0d wr_en=%0d", busy, issue_ready, vrf_wr_en);
      @(negedge clk) rst_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
